// File: rtl/pipelined_controller_if.sv
// Control/hazard bundle between pipelined_controller (slave) and the datapath (master).
// The datapath supplies the instruction, the compare result and write targets; it receives every control.
interface pipelined_controller_if #(
  parameter int unsigned REGW  = 5,
  parameter int unsigned ALUCW = 3
);
  logic [31:0]      instrD;
  logic             equalD;
  logic [REGW-1:0]  writeregE;
  logic [REGW-1:0]  writeregM;
  logic [REGW-1:0]  writeregW;

  logic             pcsrcD;
  logic             branchD;
  logic             jumpD;
  logic             regwriteD;
  logic             regwriteE;
  logic             regwriteM;
  logic             regwriteW;
  logic             memtoregE;
  logic             memtoregM;
  logic             memtoregW;
  logic             alusrcE;
  logic             regdstE;
  logic [ALUCW-1:0] alucontrolE;
  logic [REGW-1:0]  rs1D;
  logic [REGW-1:0]  rs2D;
  logic [REGW-1:0]  rs1E;
  logic [REGW-1:0]  rs2E;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic             flushD;

  modport master (
    output instrD, equalD, writeregE, writeregM, writeregW,
    input  pcsrcD, branchD, jumpD, regwriteD,
    input  regwriteE, regwriteM, regwriteW,
    input  memtoregE, memtoregM, memtoregW,
    input  alusrcE, regdstE, alucontrolE,
    input  rs1D, rs2D, rs1E, rs2E,
    input  forwardAE, forwardBE,
    input  stallF, stallD, flushE, flushD
  );

  modport slave (
    input  instrD, equalD, writeregE, writeregM, writeregW,
    output pcsrcD, branchD, jumpD, regwriteD,
    output regwriteE, regwriteM, regwriteW,
    output memtoregE, memtoregM, memtoregW,
    output alusrcE, regdstE, alucontrolE,
    output rs1D, rs2D, rs1E, rs2E,
    output forwardAE, forwardBE,
    output stallF, stallD, flushE, flushD
  );
endinterface

// File: rtl/pipelined_controller.sv
// MIPS-subset decode, E/M/W control pipeline, forwarding selects and load-use/branch hazard control.
module pipelined_controller #(
  parameter int unsigned REGW  = 5,
  parameter int unsigned ALUCW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pipelined_controller_if.slave bus
);

  typedef enum logic [5:0] {
    opRtype = 6'b000000,
    opLw    = 6'b100011,
    opSw    = 6'b101011,
    opBeq   = 6'b000100,
    opAddi  = 6'b001000,
    opJ     = 6'b000010
  } opcodeT;

  typedef enum logic [5:0] {
    fnAdd = 6'b100000,
    fnSub = 6'b100010,
    fnAnd = 6'b100100,
    fnOr  = 6'b100101,
    fnSlt = 6'b101010
  } functT;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [REGW-1:0]  rs1D;
  logic [REGW-1:0]  rs2D;
  logic             unusedInstr;

  logic             regwriteDec;
  logic             memtoregDec;
  logic             alusrcDec;
  logic             regdstDec;
  logic             branchDec;
  logic             jumpDec;
  logic [ALUCW-1:0] aluDec;

  logic             regwriteE;
  logic             memtoregE;
  logic             alusrcE;
  logic             regdstE;
  logic [ALUCW-1:0] alucontrolE;
  logic [REGW-1:0]  rs1E;
  logic [REGW-1:0]  rs2E;
  logic             regwriteM;
  logic             memtoregM;
  logic             regwriteW;
  logic             memtoregW;

  logic             lwStall;
  logic             branchStall;
  logic             stall;
  logic             pcsrcD;

  assign op          = bus.instrD[31:26];
  assign funct       = bus.instrD[5:0];
  assign rs1D        = REGW'(bus.instrD[25:21]);
  assign rs2D        = REGW'(bus.instrD[20:16]);
  assign unusedInstr = ^bus.instrD[15:6];

  always_comb begin
    regwriteDec = 1'b0;
    memtoregDec = 1'b0;
    alusrcDec   = 1'b0;
    regdstDec   = 1'b0;
    branchDec   = 1'b0;
    jumpDec     = 1'b0;
    aluDec      = '0;
    case (op)
      opRtype: begin
        regwriteDec = 1'b1;
        regdstDec   = 1'b1;
        case (funct)
          fnAdd:   aluDec = ALUCW'(3'b010);
          fnSub:   aluDec = ALUCW'(3'b110);
          fnAnd:   aluDec = ALUCW'(3'b000);
          fnOr:    aluDec = ALUCW'(3'b001);
          fnSlt:   aluDec = ALUCW'(3'b111);
          default: aluDec = ALUCW'(3'b010);
        endcase
      end
      opLw: begin
        regwriteDec = 1'b1;
        alusrcDec   = 1'b1;
        memtoregDec = 1'b1;
        aluDec      = ALUCW'(3'b010);
      end
      opSw: begin
        alusrcDec = 1'b1;
        aluDec    = ALUCW'(3'b010);
      end
      opBeq: begin
        branchDec = 1'b1;
        aluDec    = ALUCW'(3'b110);
      end
      opAddi: begin
        regwriteDec = 1'b1;
        alusrcDec   = 1'b1;
        aluDec      = ALUCW'(3'b010);
      end
      opJ: jumpDec = 1'b1;
      default: ;
    endcase
  end

  // $0 is hard-wired, so a write to it never creates a real dependency.
  function automatic logic writesEither(input logic rw, input logic [REGW-1:0] wr,
                                        input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return rw && (wr != '0) && ((wr == a) || (wr == b));
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src,
                                        input logic rwM, input logic [REGW-1:0] wrM,
                                        input logic rwW, input logic [REGW-1:0] wrW);
    if (writesEither(rwM, wrM, src, src))
      return 2'b10;
    else if (writesEither(rwW, wrW, src, src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    lwStall     = memtoregE && ((rs2E == rs1D) || (rs2E == rs2D));
    branchStall = branchDec &&
                  (writesEither(regwriteE, bus.writeregE, rs1D, rs2D) ||
                   writesEither(regwriteM, bus.writeregM, rs1D, rs2D));
    stall       = lwStall | branchStall;
    // A branch resolves only once its operands are no longer in flight.
    pcsrcD      = branchDec & bus.equalD & ~branchStall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwriteE   <= 1'b0;
      memtoregE   <= 1'b0;
      alusrcE     <= 1'b0;
      regdstE     <= 1'b0;
      alucontrolE <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      regwriteM   <= 1'b0;
      memtoregM   <= 1'b0;
      regwriteW   <= 1'b0;
      memtoregW   <= 1'b0;
    end else begin
      if (stall) begin
        regwriteE   <= 1'b0;
        memtoregE   <= 1'b0;
        alusrcE     <= 1'b0;
        regdstE     <= 1'b0;
        alucontrolE <= '0;
        rs1E        <= '0;
        rs2E        <= '0;
      end else begin
        regwriteE   <= regwriteDec;
        memtoregE   <= memtoregDec;
        alusrcE     <= alusrcDec;
        regdstE     <= regdstDec;
        alucontrolE <= aluDec;
        rs1E        <= rs1D;
        rs2E        <= rs2D;
      end
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      regwriteW <= regwriteM;
      memtoregW <= memtoregM;
    end
  end

  assign bus.pcsrcD      = pcsrcD;
  assign bus.branchD     = branchDec;
  assign bus.jumpD       = jumpDec;
  assign bus.regwriteD   = regwriteDec;
  assign bus.flushD      = pcsrcD | jumpDec;
  assign bus.rs1D        = rs1D;
  assign bus.rs2D        = rs2D;
  assign bus.regwriteE   = regwriteE;
  assign bus.regwriteM   = regwriteM;
  assign bus.regwriteW   = regwriteW;
  assign bus.memtoregE   = memtoregE;
  assign bus.memtoregM   = memtoregM;
  assign bus.memtoregW   = memtoregW;
  assign bus.alusrcE     = alusrcE;
  assign bus.regdstE     = regdstE;
  assign bus.alucontrolE = alucontrolE;
  assign bus.rs1E        = rs1E;
  assign bus.rs2E        = rs2E;
  assign bus.forwardAE   = fwdSel(rs1E, regwriteM, bus.writeregM, regwriteW, bus.writeregW);
  assign bus.forwardBE   = fwdSel(rs2E, regwriteM, bus.writeregM, regwriteW, bus.writeregW);
  assign bus.stallF      = stall;
  assign bus.stallD      = stall;
  assign bus.flushE      = stall;

endmodule

// File: tb/tb_pipelined_controller.sv
// Scoreboard bench for pipelined_controller: an instruction-level pipeline model acting as the datapath.
module tb_pipelined_controller;

  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       as;
    logic       rdst;
    logic       br;
    logic       jmp;
    logic [2:0] alu;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
  } stageT;

  typedef struct packed {
    logic       pcsrcD, branchD, jumpD, regwriteD;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM, memtoregW;
    logic       alusrcE, regdstE;
    logic [2:0] alucontrolE;
    logic [4:0] rs1D, rs2D, rs1E, rs2E;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, flushE, flushD;
  } outT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_controller_if #(.REGW(5), .ALUCW(3)) bus ();

  pipelined_controller #(.REGW(5), .ALUCW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  outT   sbq[$];
  stageT mE, mM, mW;
  int    nCompared = 0;
  int    nFailed   = 0;
  int    cyc       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic stageT decode(input logic [31:0] i);
    stageT s;
    s    = '0;
    s.rs = i[25:21];
    s.rt = i[20:16];
    case (i[31:26])
      6'h00: begin
        s.rw = 1'b1; s.rdst = 1'b1;
        case (i[5:0])
          6'h22:   s.alu = 3'b110;
          6'h24:   s.alu = 3'b000;
          6'h25:   s.alu = 3'b001;
          6'h2a:   s.alu = 3'b111;
          default: s.alu = 3'b010;
        endcase
      end
      6'h23: begin s.rw = 1'b1; s.as = 1'b1; s.mtr = 1'b1; s.alu = 3'b010; end
      6'h2b: begin s.as = 1'b1; s.alu = 3'b010; end
      6'h04: begin s.br = 1'b1; s.alu = 3'b110; end
      6'h08: begin s.rw = 1'b1; s.as = 1'b1; s.alu = 3'b010; end
      6'h02: s.jmp = 1'b1;
      default: ;
    endcase
    s.dest = s.rdst ? i[15:11] : i[20:16];
    return s;
  endfunction

  function automatic logic writes(input stageT s, input logic [4:0] r);
    return s.rw && (s.dest != 5'd0) && (s.dest == r);
  endfunction

  function automatic logic [1:0] fwd(input stageT m, input stageT w, input logic [4:0] r);
    if (writes(m, r)) return 2'b10;
    if (writes(w, r)) return 2'b01;
    return 2'b00;
  endfunction

  // One Decode cycle: present the instruction, queue what the controller must show, advance the model.
  task automatic step(input logic [31:0] ins, input logic eq, output logic stalled);
    stageT d;
    outT   e;
    logic  lws, bs;
    @(negedge clk);
    cyc++;
    bus.instrD    = ins;
    bus.equalD    = eq;
    bus.writeregE = mE.dest;
    bus.writeregM = mM.dest;
    bus.writeregW = mW.dest;
    d   = decode(ins);
    lws = mE.mtr && ((mE.rt == d.rs) || (mE.rt == d.rt));
    bs  = d.br && (writes(mE, d.rs) || writes(mE, d.rt) || writes(mM, d.rs) || writes(mM, d.rt));
    e = '0;
    e.branchD     = d.br;
    e.jumpD       = d.jmp;
    e.regwriteD   = d.rw;
    e.rs1D        = d.rs;
    e.rs2D        = d.rt;
    e.pcsrcD      = d.br && eq && !bs;
    e.flushD      = e.pcsrcD || d.jmp;
    e.regwriteE   = mE.rw;
    e.memtoregE   = mE.mtr;
    e.alusrcE     = mE.as;
    e.regdstE     = mE.rdst;
    e.alucontrolE = mE.alu;
    e.rs1E        = mE.rs;
    e.rs2E        = mE.rt;
    e.regwriteM   = mM.rw;
    e.memtoregM   = mM.mtr;
    e.regwriteW   = mW.rw;
    e.memtoregW   = mW.mtr;
    e.forwardAE   = fwd(mM, mW, mE.rs);
    e.forwardBE   = fwd(mM, mW, mE.rt);
    e.stallF      = lws || bs;
    e.stallD      = lws || bs;
    e.flushE      = lws || bs;
    sbq.push_back(e);
    stalled = lws || bs;
    if (reset) begin
      mW = mM;
      mM = mE;
      mE = stalled ? stageT'('0) : d;
    end
  endtask

  // A stalled Decode instruction is re-presented until it moves on, as the IF/ID register would hold it.
  task automatic issue(input logic [31:0] ins, input logic eq);
    logic st;
    int   guard;
    guard = 0;
    do begin
      step(ins, eq, st);
      guard++;
    end while (st && guard < 8);
    if (st) chk("stall_bound", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [5:0]  fnTab [6];
    fnTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    fn  = fnTab[$urandom_range(0, 5)];
    imm = 16'($urandom);
    case ($urandom_range(0, 8))
      0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, fn};
      3:       return {6'h23, rs, rt, imm};
      4:       return {6'h2b, rs, rt, imm};
      5, 6:    return {6'h04, rs, rt, imm};
      7:       return {6'h08, rs, rt, imm};
      default: return ($urandom_range(0, 1) == 0) ? {6'h02, 26'($urandom)} : {6'h0f, rs, rt, imm};
    endcase
  endfunction

  always begin
    outT e, a;
    @(negedge clk);
    #2;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      a.pcsrcD = bus.pcsrcD;       a.branchD = bus.branchD;     a.jumpD = bus.jumpD;
      a.regwriteD = bus.regwriteD; a.regwriteE = bus.regwriteE; a.regwriteM = bus.regwriteM;
      a.regwriteW = bus.regwriteW; a.memtoregE = bus.memtoregE; a.memtoregM = bus.memtoregM;
      a.memtoregW = bus.memtoregW; a.alusrcE = bus.alusrcE;     a.regdstE = bus.regdstE;
      a.alucontrolE = bus.alucontrolE;
      a.rs1D = bus.rs1D; a.rs2D = bus.rs2D; a.rs1E = bus.rs1E; a.rs2E = bus.rs2E;
      a.forwardAE = bus.forwardAE; a.forwardBE = bus.forwardBE;
      a.stallF = bus.stallF; a.stallD = bus.stallD; a.flushE = bus.flushE; a.flushD = bus.flushD;
      chk("pcsrcD",      32'(a.pcsrcD),      32'(e.pcsrcD));
      chk("branchD",     32'(a.branchD),     32'(e.branchD));
      chk("jumpD",       32'(a.jumpD),       32'(e.jumpD));
      chk("regwriteD",   32'(a.regwriteD),   32'(e.regwriteD));
      chk("regwriteE",   32'(a.regwriteE),   32'(e.regwriteE));
      chk("regwriteM",   32'(a.regwriteM),   32'(e.regwriteM));
      chk("regwriteW",   32'(a.regwriteW),   32'(e.regwriteW));
      chk("memtoregE",   32'(a.memtoregE),   32'(e.memtoregE));
      chk("memtoregM",   32'(a.memtoregM),   32'(e.memtoregM));
      chk("memtoregW",   32'(a.memtoregW),   32'(e.memtoregW));
      chk("alusrcE",     32'(a.alusrcE),     32'(e.alusrcE));
      chk("regdstE",     32'(a.regdstE),     32'(e.regdstE));
      chk("alucontrolE", 32'(a.alucontrolE), 32'(e.alucontrolE));
      chk("rs1D",        32'(a.rs1D),        32'(e.rs1D));
      chk("rs2D",        32'(a.rs2D),        32'(e.rs2D));
      chk("rs1E",        32'(a.rs1E),        32'(e.rs1E));
      chk("rs2E",        32'(a.rs2E),        32'(e.rs2E));
      chk("forwardAE",   32'(a.forwardAE),   32'(e.forwardAE));
      chk("forwardBE",   32'(a.forwardBE),   32'(e.forwardBE));
      chk("stallF",      32'(a.stallF),      32'(e.stallF));
      chk("stallD",      32'(a.stallD),      32'(e.stallD));
      chk("flushE",      32'(a.flushE),      32'(e.flushE));
      chk("flushD",      32'(a.flushD),      32'(e.flushD));
    end
  end

  task automatic releaseReset();
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    logic st;
    mE = '0; mM = '0; mW = '0;
    reset         = 1'b0;
    bus.instrD    = '0;
    bus.equalD    = 1'b0;
    bus.writeregE = '0;
    bus.writeregM = '0;
    bus.writeregW = '0;

    step(32'h0000_0000, 1'b0, st);
    releaseReset();

    issue(32'h8C22_0000, 1'b0);   // lw  $2,0($1)
    issue(32'h0045_2020, 1'b0);   // add $4,$2,$5 (load-use)
    issue(32'h0000_0000, 1'b0);
    issue(32'h0000_0000, 1'b0);
    issue(32'h0021_1820, 1'b0);   // add $3,$1,$1
    issue(32'h0021_1820, 1'b0);   // add $3,$1,$1
    issue(32'h0060_2820, 1'b0);   // add $5,$3,$0
    issue(32'h0000_0000, 1'b0);
    issue(32'h1022_0004, 1'b1);   // beq $1,$2 taken, no hazard
    issue(32'h0000_0820, 1'b0);   // add $1,$0,$0
    issue(32'h1022_0004, 1'b1);   // beq $1,$2 behind add $1
    issue(32'h0800_0010, 1'b0);   // j
    issue(32'h0022_3022, 1'b0);   // sub $6,$1,$2
    issue(32'h0000_0000, 1'b0);

    // Asynchronous reset between edges with live control words in E/M/W.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_regwriteE",   32'(bus.regwriteE),   32'd0);
    chk("rst_regwriteM",   32'(bus.regwriteM),   32'd0);
    chk("rst_regwriteW",   32'(bus.regwriteW),   32'd0);
    chk("rst_memtoregE",   32'(bus.memtoregE),   32'd0);
    chk("rst_memtoregM",   32'(bus.memtoregM),   32'd0);
    chk("rst_memtoregW",   32'(bus.memtoregW),   32'd0);
    chk("rst_alucontrolE", 32'(bus.alucontrolE), 32'd0);
    chk("rst_rs1E",        32'(bus.rs1E),        32'd0);
    chk("rst_forwardAE",   32'(bus.forwardAE),   32'd0);
    chk("rst_forwardBE",   32'(bus.forwardBE),   32'd0);
    mE = '0; mM = '0; mW = '0;
    step(32'h0000_0000, 1'b0, st);
    releaseReset();

    for (int n = 0; n < 400; n++)
      issue(randInstr(), 1'($urandom_range(0, 1)));

    @(negedge clk);
    #4;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
